// File: rtl/vdm_pkg.sv
// vdm_pkg: shared types and constants for voq_delay_monitor.
//   snap_state_t   - snapshot FSM states (RUN, DRAIN, CAPT)
//   SAT_GUARD_BITS - extra carry bit on every saturating adder
//   MAX_WIDTH      - widest accumulator the constants below cover
//   MIN_INIT       - all-ones value loaded into min trackers (empty window)
package vdm_pkg;

    typedef enum logic [1:0] {
        SNAP_RUN   = 2'd0,
        SNAP_DRAIN = 2'd1,
        SNAP_CAPT  = 2'd2
    } snap_state_t;

    localparam int unsigned SAT_GUARD_BITS = 1;
    localparam int unsigned MAX_WIDTH      = 64;

    // Slice [WIDTH-1:0] for a WIDTH-bit all-ones minimum seed.
    localparam logic [MAX_WIDTH-1:0] MIN_INIT = '1;

endpackage

// File: rtl/vdm_accum.sv
// vdm_accum: one set of delay statistics with saturating arithmetic.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   clear          - zero the set (min reloads all-ones), same effect as reset
//   en             - accumulate delay this cycle
//   delay          - WIDTH-bit delay sample
//   cnt            - number of accumulated samples, saturates at all-ones
//   total          - 2*WIDTH sum of samples, saturates at all-ones
//   min_delay      - smallest sample seen (all-ones when empty)
//   max_delay      - largest sample seen (0 when empty)
//   sat            - sticky: cnt or total clamped since the last clear
module vdm_accum
    import vdm_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 en,
    input  logic [WIDTH-1:0]     delay,
    output logic [WIDTH-1:0]     cnt,
    output logic [2*WIDTH-1:0]   total,
    output logic [WIDTH-1:0]     min_delay,
    output logic [WIDTH-1:0]     max_delay,
    output logic                 sat
);

    localparam int unsigned CW = WIDTH + SAT_GUARD_BITS;
    localparam int unsigned TW = 2 * WIDTH + SAT_GUARD_BITS;

    logic [CW-1:0] cnt_sum;
    logic [TW-1:0] tot_sum;
    logic          cnt_carry;
    logic          tot_carry;

    always_comb begin
        cnt_sum   = {{SAT_GUARD_BITS{1'b0}}, cnt} + CW'(1);
        tot_sum   = {{SAT_GUARD_BITS{1'b0}}, total} + TW'(delay);
        cnt_carry = cnt_sum[CW-1];
        tot_carry = tot_sum[TW-1];
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt       <= '0;
            total     <= '0;
            min_delay <= MIN_INIT[WIDTH-1:0];
            max_delay <= '0;
            sat       <= 1'b0;
        end else if (en) begin
            cnt       <= cnt_carry ? '1 : cnt_sum[WIDTH-1:0];
            total     <= tot_carry ? '1 : tot_sum[2*WIDTH-1:0];
            if (delay < min_delay) min_delay <= delay;
            if (delay > max_delay) max_delay <= delay;
            sat       <= sat | cnt_carry | tot_carry;
        end
    end

endmodule

// File: rtl/voq_delay_monitor.sv
// voq_delay_monitor: queueing-delay / throughput monitor on a VOQ read port.
// Each dequeued word carries its arrival timestamp; delay = i_time - i_data
// (modulo 2^WIDTH). Aggregate count/total/min/max are accumulated and a
// snapshot FSM (RUN -> DRAIN -> CAPT) publishes a coherent copy.
// Optional feature macro: VDM_PER_PRIO_EN adds per-class count/total
// accumulators and the o_prio_cnt / o_prio_total snapshot ports.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   i_wr                 - arrival strobe (counted into cnt_in)
//   i_rd, i_rd_priority  - dequeue strobe and one-hot class of the word
//   i_data, i_time       - arrival timestamp and free-running time base
//   i_clear              - zero all accumulators, abort any snapshot
//   i_snap_req           - snapshot request pulse (ignored while busy)
//   o_snap_busy          - snapshot in progress
//   o_snap_valid         - one-cycle pulse when snapshot outputs update
//   o_cnt_in, o_cnt_out  - snapshot arrival / departure counts
//   o_min_delay, o_max_delay, o_total_delay - snapshot delay statistics
//   o_overflow           - sticky saturation indicator (live, not snapshot)
//   o_prio_cnt, o_prio_total - per-class snapshot (VDM_PER_PRIO_EN only)
module voq_delay_monitor
    import vdm_pkg::*;
#(
    parameter int unsigned PORT     = 8,
    parameter int unsigned PRIORITY = 4,
    parameter int unsigned WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr,
    input  logic                     i_rd,
    input  logic [PRIORITY-1:0]      i_rd_priority,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [WIDTH-1:0]         i_time,
    input  logic                     i_clear,
    input  logic                     i_snap_req,
    output logic                     o_snap_busy,
    output logic                     o_snap_valid,
    output logic [WIDTH-1:0]         o_cnt_in,
    output logic [WIDTH-1:0]         o_cnt_out,
    output logic [WIDTH-1:0]         o_min_delay,
    output logic [WIDTH-1:0]         o_max_delay,
    output logic [2*WIDTH-1:0]       o_total_delay,
    output logic                     o_overflow
`ifdef VDM_PER_PRIO_EN
    ,
    output logic [PRIORITY*WIDTH-1:0]   o_prio_cnt,
    output logic [PRIORITY*2*WIDTH-1:0] o_prio_total
`endif
);

    // PORT is informational only.
    localparam int unsigned PORT_UNUSED = PORT;

    snap_state_t state;

    logic [WIDTH-1:0]   d1;
    logic               v1;

    logic [WIDTH:0]     cnt_in_sum;
    logic [WIDTH-1:0]   cnt_in;
    logic [WIDTH-1:0]   cnt_in_nxt;
    logic               cnt_in_carry;
    logic               cnt_in_sat;
    logic [WIDTH-1:0]   cnt_in_hold;

    logic [WIDTH-1:0]   agg_cnt;
    logic [2*WIDTH-1:0] agg_total;
    logic [WIDTH-1:0]   agg_min;
    logic [WIDTH-1:0]   agg_max;
    logic               agg_sat;

    // Stage 1: register the wrap-safe delay alongside the dequeue strobe.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            v1 <= 1'b0;
            d1 <= '0;
        end else begin
            v1 <= i_rd;
            d1 <= i_time - i_data;
        end
    end

    // Arrivals bypass the pipeline.
    always_comb begin
        cnt_in_sum   = {1'b0, cnt_in} + (WIDTH + 1)'(i_wr);
        cnt_in_carry = cnt_in_sum[WIDTH];
        cnt_in_nxt   = cnt_in_carry ? '1 : cnt_in_sum[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            cnt_in     <= '0;
            cnt_in_sat <= 1'b0;
        end else begin
            cnt_in     <= cnt_in_nxt;
            cnt_in_sat <= cnt_in_sat | cnt_in_carry;
        end
    end

    // Stage 2: aggregate statistics.
    vdm_accum #(.WIDTH(WIDTH)) u_agg (
        .clk       (clk),
        .reset     (reset),
        .clear     (i_clear),
        .en        (v1),
        .delay     (d1),
        .cnt       (agg_cnt),
        .total     (agg_total),
        .min_delay (agg_min),
        .max_delay (agg_max),
        .sat       (agg_sat)
    );

`ifdef VDM_PER_PRIO_EN
    logic [PRIORITY-1:0]          p1;
    logic [PRIORITY-1:0]          prio_sat;
    logic [PRIORITY*WIDTH-1:0]    prio_cnt;
    logic [PRIORITY*2*WIDTH-1:0]  prio_total;
    logic [PRIORITY*WIDTH-1:0]    prio_min_unused;
    logic [PRIORITY*WIDTH-1:0]    prio_max_unused;

    always_ff @(posedge clk) begin
        if (reset || i_clear) p1 <= '0;
        else                  p1 <= i_rd_priority;
    end

    // Multi-hot p1 updates every set class; all-zero updates none.
    for (genvar k = 0; k < PRIORITY; k++) begin : g_prio
        vdm_accum #(.WIDTH(WIDTH)) u_acc (
            .clk       (clk),
            .reset     (reset),
            .clear     (i_clear),
            .en        (v1 & p1[k]),
            .delay     (d1),
            .cnt       (prio_cnt[k*WIDTH +: WIDTH]),
            .total     (prio_total[k*2*WIDTH +: 2*WIDTH]),
            .min_delay (prio_min_unused[k*WIDTH +: WIDTH]),
            .max_delay (prio_max_unused[k*WIDTH +: WIDTH]),
            .sat       (prio_sat[k])
        );
    end

    always_comb o_overflow = agg_sat | cnt_in_sat | (|prio_sat);
`else
    logic prio_unused;
    always_comb prio_unused = ^i_rd_priority;

    always_comb o_overflow = agg_sat | cnt_in_sat;
`endif

    // Snapshot FSM. cnt_in is latched on the request cycle (including that
    // cycle's i_wr) so it lines up with the two-stage departure pipeline,
    // which has drained the request-cycle i_rd by the time CAPT copies.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SNAP_RUN;
            o_snap_busy   <= 1'b0;
            o_snap_valid  <= 1'b0;
            cnt_in_hold   <= '0;
            o_cnt_in      <= '0;
            o_cnt_out     <= '0;
            o_min_delay   <= MIN_INIT[WIDTH-1:0];
            o_max_delay   <= '0;
            o_total_delay <= '0;
`ifdef VDM_PER_PRIO_EN
            o_prio_cnt    <= '0;
            o_prio_total  <= '0;
`endif
        end else begin
            o_snap_valid <= 1'b0;
            if (i_clear) begin
                state       <= SNAP_RUN;
                o_snap_busy <= 1'b0;
            end else begin
                case (state)
                    SNAP_RUN: begin
                        if (i_snap_req) begin
                            state       <= SNAP_DRAIN;
                            o_snap_busy <= 1'b1;
                            cnt_in_hold <= cnt_in_nxt;
                        end
                    end
                    SNAP_DRAIN: begin
                        state <= SNAP_CAPT;
                    end
                    SNAP_CAPT: begin
                        state         <= SNAP_RUN;
                        o_snap_busy   <= 1'b0;
                        o_snap_valid  <= 1'b1;
                        o_cnt_in      <= cnt_in_hold;
                        o_cnt_out     <= agg_cnt;
                        o_min_delay   <= agg_min;
                        o_max_delay   <= agg_max;
                        o_total_delay <= agg_total;
`ifdef VDM_PER_PRIO_EN
                        o_prio_cnt    <= prio_cnt;
                        o_prio_total  <= prio_total;
`endif
                    end
                    default: begin
                        state       <= SNAP_RUN;
                        o_snap_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
